// File: rtl/dmi_arbiter_pkg.sv
// Shared debug-module types: DMI request/response payloads and op/response codes.
package dm;

  localparam logic [1:0] DTM_NOP     = 2'h0;
  localparam logic [1:0] DTM_READ    = 2'h1;
  localparam logic [1:0] DTM_WRITE   = 2'h2;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_FAILED  = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after i_last, wrapping.
module dmi_rr_picker #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdxW-1:0]   i_last,
  output logic [IdxW-1:0]   o_pick,
  output logic              o_pick_valid
);

  logic [IdxW-1:0] w_cand;

  // Scan from i_last+1 around the ring; the first hit wins.
  always_comb begin
    o_pick       = '0;
    o_pick_valid = 1'b0;
    w_cand       = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      w_cand = IdxW'((32'(i_last) + k) % NumReq);
      if (!o_pick_valid && i_valid[w_cand]) begin
        o_pick       = w_cand;
        o_pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI port between NumReq requesters, one transaction in flight,
// round-robin grant, response routing and a response timeout that swallows
// the late beat before any new request is issued.
module dmi_arbiter
  import dm::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  dm::dmi_req_t [NumReq-1:0] req_i,
  output logic [NumReq-1:0]     resp_valid_o,
  input  logic [NumReq-1:0]     resp_ready_i,
  output dm::dmi_resp_t         resp_o,
  output dm::dmi_req_t          dmi_req_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  input  dm::dmi_resp_t         dmi_resp_i,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned TimerW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [TimerW-1:0] TimerLast = TimeoutEn ? TimerW'(TimeoutCycles - 1) : '0;
  localparam logic [IdxW-1:0]   LastInit  = IdxW'(NumReq - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, RET} state_e;

  state_e            r_state, w_state_n;
  dmi_req_t          r_req, w_req_n;
  dmi_resp_t         r_resp, w_resp_n;
  logic [IdxW-1:0]   r_idx, w_idx_n;
  logic [IdxW-1:0]   r_last, w_last_n;
  logic [TimerW-1:0] r_timer, w_timer_n;
  logic              r_late, w_late_n;

  logic [IdxW-1:0]   w_pick;
  logic              w_pick_valid;

  dmi_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .i_valid      (req_valid_i),
    .i_last       (r_last),
    .o_pick       (w_pick),
    .o_pick_valid (w_pick_valid)
  );

  // State and held transaction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_resp  <= '0;
      r_idx   <= '0;
      r_last  <= LastInit;
      r_timer <= '0;
      r_late  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_resp  <= w_resp_n;
      r_idx   <= w_idx_n;
      r_last  <= w_last_n;
      r_timer <= w_timer_n;
      r_late  <= w_late_n;
    end
  end

  // Next-state, handshakes and timeout bookkeeping.
  always_comb begin
    w_state_n        = r_state;
    w_req_n          = r_req;
    w_resp_n         = r_resp;
    w_idx_n          = r_idx;
    w_last_n         = r_last;
    w_timer_n        = r_timer;
    w_late_n         = r_late;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = r_late;

    unique case (r_state)
      IDLE: begin
        // A late beat must drain before the DM sees another request.
        if (!r_late && w_pick_valid) begin
          req_ready_o[w_pick] = 1'b1;
          w_req_n             = req_i[w_pick];
          w_idx_n             = w_pick;
          w_state_n           = REQ;
        end
      end
      REQ: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          w_timer_n = '0;
          w_state_n = RESP;
        end
      end
      RESP: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          w_resp_n  = dmi_resp_i;
          w_state_n = RET;
        end else begin
          if (r_timer != '1) w_timer_n = r_timer + 1'b1;
          if (TimeoutEn && (r_timer == TimerLast)) begin
            w_resp_n  = '{data: 32'h0, resp: DTM_FAILED};
            w_late_n  = 1'b1;
            w_state_n = RET;
          end
        end
      end
      RET: begin
        resp_valid_o[r_idx] = 1'b1;
        if (resp_ready_i[r_idx]) begin
          w_last_n  = r_idx;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    // r_late is never set while in RESP, so this cannot steal a live response.
    if (r_late && dmi_resp_valid_i) w_late_n = 1'b0;
  end

  assign dmi_req_o = r_req;
  assign resp_o    = r_resp;
  assign busy_o    = (r_state != IDLE) || r_late;

`ifndef SYNTHESIS
  a_no_stray_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    dmi_resp_valid_i |-> dmi_resp_ready_o)
    else $error("dmi_arbiter: DM response with no transaction waiting");

  for (genvar g = 0; g < NumReq; g++) begin : g_req_chk
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g])
      else $error("dmi_arbiter: requester %0d dropped valid before ready", g);
  end
`endif

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the debug module's single DMI request/response port between NumReq requesters, e.g. the JTAG CDC output and an on-chip debug-access path.
- Sits in the core clock domain, downstream of the async FIFOs.
- Keeps one transaction outstanding at a time and arbitrates round-robin.
- Routes each response back to the requester that issued the request.
- Applies a response timeout and discards any response that arrives after the timeout.

Parameters:
- NumReq, 2, number of requesters (at least 2).
- TimeoutCycles, 1024, cycles to wait in RESP before returning a failure; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester request accepted
- req_i  in  NumReq x dm::dmi_req_t  per-requester request payload
- resp_valid_o  out  NumReq  per-requester response valid
- resp_ready_i  in  NumReq  per-requester response ready
- resp_o  out  dm::dmi_resp_t  response payload, shared by all requesters (qualified by resp_valid_o)
- dmi_req_o  out  dm::dmi_req_t  request to the DM
- dmi_req_valid_o  out  1  request valid to the DM
- dmi_req_ready_i  in  1  DM accepts the request
- dmi_resp_i  in  dm::dmi_resp_t  response from the DM
- dmi_resp_valid_i  in  1  DM response valid
- dmi_resp_ready_o  out  1  arbiter accepts the DM response
- busy_o  out  1  high whenever state is not IDLE or late_pending=1

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, all valid/ready outputs 0, held payloads 0.
  - late_pending=0, timer=0.
  - last_grant=NumReq-1, so requester 0 wins first.
- IDLE:
  - If late_pending=0 and any req_valid_i is set, pick the first set bit searching from last_grant+1 modulo NumReq.
  - Assert req_ready_o[pick] combinationally in the same cycle.
  - On the clock edge: capture req_i[pick] into req_q and pick into idx_q, then go to REQ.
  - At most one req_ready_o bit is high in any cycle.
  - While late_pending=1, all req_ready_o stay 0.
- REQ:
  - dmi_req_valid_o=1 and dmi_req_o=req_q; both stay stable until dmi_req_ready_i.
  - On the handshake: go to RESP and clear the timer.
  - Latency from requester acceptance to dmi_req_valid_o is 1 cycle.
- RESP:
  - dmi_resp_ready_o=1.
  - If dmi_resp_valid_i: capture dmi_resp_i into resp_q and go to RET.
  - Otherwise the timer increments. When timer==TimeoutCycles-1 (and TimeoutCycles≠0):
    - resp_q = {data=32'h0, resp=2'b10 (failed)};
    - set late_pending=1;
    - go to RET.
  - If a response and the timeout expiry coincide, the response wins and no late_pending is set.
- RET:
  - resp_valid_o[idx_q]=1, all other bits 0; resp_o=resp_q.
  - On resp_ready_i[idx_q]: last_grant=idx_q, go to IDLE.
  - Minimum response latency (DM valid to resp_valid_o) is 1 cycle.
- late_pending:
  - Whenever late_pending=1, dmi_resp_ready_o=1 in every state.
  - A dmi_resp_valid_i beat is then discarded and clears late_pending.
  - Ordering guarantee: a late response is never forwarded, and the next DMI request is not issued until it has drained.
- Timer width is $clog2(TimeoutCycles+1); it saturates and never wraps.
- Outside RESP and the late_pending case, dmi_resp_ready_o=0. A stray dmi_resp_valid_i is ignored and flagged by an assertion.
- Requester rules (asserted):
  - req_valid_i must not drop before req_ready_o.
  - resp_ready_i may be held low indefinitely (RET simply waits).
- Reset mid-operation: every state returns to reset values and the held transaction is lost. The integrator resets the DM together with the arbiter.

Decomposition:
- Shared package (dm): dmi_req_t, dmi_resp_t, and a DMI response-code constant DTM_FAILED=2'b10 (added next to the existing op codes).
- State enum {IDLE, REQ, RESP, RET} is local to dmi_arbiter.
- One sub-module, dmi_rr_picker: combinational round-robin picker.
  - Inputs: valid vector, last_grant.
  - Outputs: pick index and a pick-valid bit.
  - Reusable by other debug-path arbiters.

Test Plan:
- Single request: req_valid_i[0]=1 with {addr=7'h10, op=read}; DM ready immediately and responds {data=32'hDEADBEEF, resp=0} 2 cycles later → req_ready_o[0] pulses once, resp_valid_o[0]=1 with that data, resp_valid_o[1]=0.
- Contention: both requesters valid continuously, 4 transactions → grant order 0,1,0,1; every response goes to the matching index.
- Back-pressure: dmi_req_ready_i low for 5 cycles, resp_ready_i[1] low for 3 cycles → dmi_req_o is stable throughout, resp_o is held, no transaction is lost or duplicated.
- Timeout: TimeoutCycles=8, DM never responds → after 8 RESP cycles the requester receives resp=2'b10, data=0, and busy_o stays 1 because late_pending=1.
- Late drain: continue the timeout case with the DM responding 20 cycles later while requester 1 is waiting → that response is discarded, and dmi_req_valid_o for requester 1 rises only after the discard.
- Reset mid-REQ: assert rst_i while dmi_req_valid_o=1 → next cycle all outputs are 0, state is IDLE, and the next grant goes to requester 0.
